fsm_initiator: RTL and testbench
================================

FSM_INITIATOR -- requirements
Module: fsm_initiator

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_COUNT, default 24'd120000, giving the clk cycles a raw button level must be stable before it is accepted (10 ms at 12 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_COUNT, default 27'd100000000, giving the maximum clk cycles from go assertion to done before error.
REQ-003 The block SHALL have port clk, input, 1, the single system clock (12 MHz).
REQ-004 The block SHALL have port rst_btn, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port go_btn, input, 1, the raw active-low start button, asynchronous to clk.
REQ-006 The block SHALL have port led_in, input, 4, the responder's count value, used as the start acknowledge.
REQ-007 The block SHALL have port done_sig, input, 1, the responder's active-high done level.
REQ-008 The block SHALL have port go, output, 1, the active-high run request to the responder.
REQ-009 The block SHALL have port busy, output, 1, high while a run is outstanding.
REQ-010 The block SHALL have port done_pulse, output, 1, a one-clk pulse per completed run.
REQ-011 The block SHALL have port run_count, output, 4, the number of completed runs.
REQ-012 The block SHALL have port err, output, 1, the sticky timeout flag.

Function
REQ-013 go_btn, done_sig and led_in SHALL each pass a 2-flop synchronizer before use.
REQ-014 The debouncer SHALL accept a new button level only after it is stable for DEBOUNCE_COUNT consecutive clks, and SHALL emit press as a 1-clk pulse on the accepted released-to-pressed transition.
REQ-015 done_sig SHALL be rising-edge detected after synchronization, giving done_rise as a 1-clk pulse.
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT_DONE, COMPLETE and ERROR.
REQ-017 In IDLE, press SHALL move the FSM to REQ; otherwise it stays in IDLE.
REQ-018 In REQ, go=1; synced led_in != 0 SHALL move the FSM to WAIT_DONE; done_rise SHALL move it directly to COMPLETE, with done_rise taking priority over led_in.
REQ-019 In WAIT_DONE, go=0; done_rise SHALL move the FSM to COMPLETE.
REQ-020 COMPLETE SHALL last exactly one clk, assert done_pulse, increment run_count, and then return to IDLE.
REQ-021 run_count SHALL be 4-bit unsigned and wrap 15 -> 0 on the next completion.
REQ-022 The 27-bit timeout counter SHALL clear on entry to REQ and increment each clk in REQ or WAIT_DONE.
REQ-023 When the timeout counter equals TIMEOUT_COUNT, the FSM SHALL move to ERROR and set err=1; done_rise in that same cycle SHALL take priority and go to COMPLETE instead.
REQ-024 In ERROR, go=0 and busy=0; press SHALL clear err and move the FSM to REQ, which is the only way to clear err except reset.
REQ-025 press while in REQ, WAIT_DONE or COMPLETE SHALL be ignored and not queued.
REQ-026 busy SHALL be 1 exactly in REQ, WAIT_DONE and COMPLETE.
REQ-027 All outputs SHALL be registered or decoded only from the state register (Moore); there SHALL be no combinational path from inputs to outputs.

Reset
REQ-028 rst_btn=0 SHALL asynchronously force state=IDLE, go=0, busy=0, done_pulse=0, run_count=0, err=0, and clear all counters, synchronizers and debouncer registers.
REQ-029 The debouncer SHALL reset to the released level so that a button held through reset yields no press until it is released and pressed again.
REQ-030 Reset release SHALL be usable synchronously; reset asserted mid-run SHALL abort the run with no done_pulse.

Structure
REQ-031 State encodings (3-bit) and the default DEBOUNCE_COUNT and TIMEOUT_COUNT values SHALL live in the shared fsm_defs package/include, alongside the responder's state encodings.
REQ-032 The synchronizer, debounce counter and press edge detector SHALL form one sub-module, button_debouncer, parameterized by DEBOUNCE_COUNT.

Verification (DEBOUNCE_COUNT=4, TIMEOUT_COUNT=50)
REQ-033 The bench SHALL check: go_btn low for 2 clks then high -> no press, go stays 0.
REQ-034 The bench SHALL check: go_btn held low 10 clks, led_in=1 after 5 clks, done_sig high after 20 clks -> go high until led_in is seen, then exactly one done_pulse, run_count=1, busy=0.
REQ-035 The bench SHALL check: no done_sig after press -> err=1 and state=ERROR 50 clks after REQ entry, go=0; a second press clears err and re-asserts go.
REQ-036 The bench SHALL check: 16 completed runs -> run_count wraps to 0 and 16 done_pulses are counted.
REQ-037 The bench SHALL check: press during WAIT_DONE -> ignored, and only one run is completed.
REQ-038 The bench SHALL check: rst_btn=0 in WAIT_DONE -> all outputs 0 immediately, and no done_pulse when done_sig later rises.

Source files
------------

// File: rtl/fsm_defs.sv
// Shared definitions for the initiator/responder handshake pair: state encodings
// and default timing parameters.
package fsm_defs;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_DONE = 3'd2,
        COMPLETE  = 3'd3,
        ERROR     = 3'd4
    } init_state_t;

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_COUNT = 3'd1,
        R_DONE  = 3'd2
    } resp_state_t;

    localparam logic [23:0] DEF_DEBOUNCE_COUNT = 24'd120000;
    localparam logic [26:0] DEF_TIMEOUT_COUNT  = 27'd100000000;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes an active-low button, debounces it and emits a one-clk press pulse
// on each accepted released-to-pressed transition.
module button_debouncer
    import fsm_defs::*;
#(
    parameter logic [23:0] DEBOUNCE_COUNT = DEF_DEBOUNCE_COUNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic        sync1;
    logic        sync2;
    logic        level;
    logic [23:0] cnt;

    // Everything resets to the released level so a button held through reset
    // must be released and pressed again to register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DEBOUNCE_COUNT - 24'd1) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 24'd1;
            end
        end
    end

endmodule

// File: rtl/fsm_initiator.sv
// Run-request initiator: a debounced button press issues go to a responder,
// waits for its done level and counts completed runs, flagging a sticky timeout.
module fsm_initiator
    import fsm_defs::*;
#(
    parameter logic [23:0] DEBOUNCE_COUNT = DEF_DEBOUNCE_COUNT,
    parameter logic [26:0] TIMEOUT_COUNT  = DEF_TIMEOUT_COUNT
) (
    input  logic       clk,
    input  logic       rst_btn,
    input  logic       go_btn,
    input  logic [3:0] led_in,
    input  logic       done_sig,
    output logic       go,
    output logic       busy,
    output logic       done_pulse,
    output logic [3:0] run_count,
    output logic       err
);

    init_state_t state;
    init_state_t state_next;
    logic        press;
    logic [3:0]  led_s1;
    logic [3:0]  led_s2;
    logic        done_s1;
    logic        done_s2;
    logic        done_prev;
    logic        done_rise;
    logic        timeout_hit;
    logic [26:0] tcount;

    button_debouncer #(
        .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
    ) u_debouncer (
        .clk  (clk),
        .rst_n(rst_btn),
        .btn  (go_btn),
        .press(press)
    );

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            led_s1    <= '0;
            led_s2    <= '0;
            done_s1   <= 1'b0;
            done_s2   <= 1'b0;
            done_prev <= 1'b0;
        end else begin
            led_s1    <= led_in;
            led_s2    <= led_s1;
            done_s1   <= done_sig;
            done_s2   <= done_s1;
            done_prev <= done_s2;
        end
    end

    assign done_rise = done_s2 & ~done_prev;

    // The timeout fires on the clk where the counter reaches TIMEOUT_COUNT, so
    // ERROR is entered exactly TIMEOUT_COUNT clks after REQ entry.
    assign timeout_hit = (tcount + 27'd1) == TIMEOUT_COUNT;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (press) state_next = REQ;
            REQ: begin
                if (done_rise)           state_next = COMPLETE;
                else if (timeout_hit)    state_next = ERROR;
                else if (led_s2 != '0)   state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_rise)           state_next = COMPLETE;
                else if (timeout_hit)    state_next = ERROR;
            end
            COMPLETE:  state_next = IDLE;
            ERROR:     if (press) state_next = REQ;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state      <= IDLE;
            go         <= 1'b0;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
            run_count  <= '0;
            err        <= 1'b0;
            tcount     <= '0;
        end else begin
            state      <= state_next;
            go         <= (state_next == REQ);
            busy       <= (state_next == REQ) || (state_next == WAIT_DONE) ||
                          (state_next == COMPLETE);
            done_pulse <= (state_next == COMPLETE);
            err        <= (state_next == ERROR);
            if (state_next == COMPLETE)
                run_count <= run_count + 4'd1;
            if ((state_next == REQ) && (state != REQ))
                tcount <= '0;
            else if ((state == REQ) || (state == WAIT_DONE))
                tcount <= tcount + 27'd1;
        end
    end

endmodule

// File: tb/tb_fsm_initiator.sv
// Directed bench for fsm_initiator with short debounce and timeout values.
module tb_fsm_initiator;
    import fsm_defs::*;

    logic       clk;
    logic       rst_btn;
    logic       go_btn;
    logic [3:0] led_in;
    logic       done_sig;
    logic       go;
    logic       busy;
    logic       done_pulse;
    logic [3:0] run_count;
    logic       err;

    int unsigned n_checks;
    int unsigned n_pass;
    int unsigned pulses;
    int unsigned go_cycles;
    int unsigned pulse_cycles;
    int unsigned base;
    logic        ok;

    fsm_initiator #(
        .DEBOUNCE_COUNT(24'd4),
        .TIMEOUT_COUNT (27'd50)
    ) dut (
        .clk       (clk),
        .rst_btn   (rst_btn),
        .go_btn    (go_btn),
        .led_in    (led_in),
        .done_sig  (done_sig),
        .go        (go),
        .busy      (busy),
        .done_pulse(done_pulse),
        .run_count (run_count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done_pulse === 1'b1) pulses++;

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_busy(input logic level, input int unsigned budget, output logic hit);
        hit = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            step(1);
            if (busy === level) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    // Press, get acknowledged via led_in, then complete via done_sig.
    task automatic do_run(output logic hit);
        logic h1, h2;
        go_btn = 1'b0;
        wait_busy(1'b1, 30, h1);
        go_btn = 1'b1;
        led_in = 4'd1;
        step(3);
        done_sig = 1'b1;
        wait_busy(1'b0, 30, h2);
        done_sig = 1'b0;
        led_in   = 4'd0;
        step(8);
        hit = h1 & h2;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; pulses = 0;
        rst_btn = 1'b0; go_btn = 1'b1; led_in = 4'd0; done_sig = 1'b0;
        step(3);
        check("reset_go", 32'(go), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done_pulse", 32'(done_pulse), 0);
        check("reset_run_count", 32'(run_count), 0);
        check("reset_err", 32'(err), 0);
        rst_btn = 1'b1;
        step(3);

        // Short glitch below debounce length
        go_cycles = 0;
        go_btn = 1'b0;
        step(2);
        go_btn = 1'b1;
        for (int unsigned i = 0; i < 15; i++) begin
            step(1);
            if (go === 1'b1) go_cycles++;
        end
        check("glitch_go", go_cycles, 0);
        check("glitch_busy", 32'(busy), 0);

        // Acknowledged run: go is high for one clk before led_in is seen
        go_cycles = 0; pulse_cycles = 0;
        for (int unsigned i = 0; i < 40; i++) begin
            if (go === 1'b1) go_cycles++;
            if (done_pulse === 1'b1) pulse_cycles++;
            go_btn   = (i < 10) ? 1'b0 : 1'b1;
            led_in   = (i >= 5) ? 4'd1 : 4'd0;
            done_sig = (i >= 20);
            step(1);
        end
        check("run_go_cycles", go_cycles, 1);
        check("run_done_pulses", pulse_cycles, 1);
        check("run_count_1", 32'(run_count), 1);
        check("run_busy", 32'(busy), 0);
        check("run_err", 32'(err), 0);
        done_sig = 1'b0; led_in = 4'd0;
        step(8);

        // Timeout into ERROR, then recovery by a second press
        go_btn = 1'b0;
        ok = 1'b0;
        for (int unsigned i = 0; i < 20; i++) begin
            step(1);
            if (go === 1'b1) begin ok = 1'b1; break; end
        end
        check("to_go_seen", 32'(ok), 1);
        go_btn = 1'b1;
        step(49);
        check("to_err_before", 32'(err), 0);
        check("to_go_before", 32'(go), 1);
        step(1);
        check("to_err", 32'(err), 1);
        check("to_state", 32'(dut.state), 32'(ERROR));
        check("to_go", 32'(go), 0);
        check("to_busy", 32'(busy), 0);
        step(5);
        check("to_err_sticky", 32'(err), 1);
        go_btn = 1'b0;
        wait_busy(1'b1, 30, ok);
        check("recover_busy", 32'(ok), 1);
        check("recover_err", 32'(err), 0);
        check("recover_go", 32'(go), 1);
        go_btn = 1'b1; led_in = 4'd2;
        step(3);
        done_sig = 1'b1;
        wait_busy(1'b0, 30, ok);
        check("recover_done", 32'(ok), 1);
        check("run_count_2", 32'(run_count), 2);
        done_sig = 1'b0; led_in = 4'd0;
        step(8);

        // 16 runs from reset wrap run_count to 0
        rst_btn = 1'b0;
        step(2);
        rst_btn = 1'b1;
        step(2);
        base = pulses;
        for (int unsigned r = 0; r < 15; r++) begin
            do_run(ok);
            check("wrap_run_done", 32'(ok), 1);
        end
        check("wrap_count_15", 32'(run_count), 15);
        do_run(ok);
        check("wrap_run_done", 32'(ok), 1);
        check("wrap_count_0", 32'(run_count), 0);
        check("wrap_pulses", pulses - base, 16);

        // Press during WAIT_DONE is ignored
        base = pulses;
        go_btn = 1'b0;
        wait_busy(1'b1, 30, ok);
        check("ign_busy", 32'(ok), 1);
        go_btn = 1'b1; led_in = 4'd3;
        step(10);
        go_btn = 1'b0;
        step(8);
        go_btn = 1'b1;
        step(8);
        check("ign_state", 32'(dut.state), 32'(WAIT_DONE));
        check("ign_go", 32'(go), 0);
        done_sig = 1'b1;
        wait_busy(1'b0, 30, ok);
        check("ign_done", 32'(ok), 1);
        done_sig = 1'b0; led_in = 4'd0;
        step(20);
        check("ign_idle", 32'(busy), 0);
        check("ign_pulses", pulses - base, 1);
        check("ign_count", 32'(run_count), 1);

        // Reset mid-run aborts without a done_pulse
        go_btn = 1'b0;
        wait_busy(1'b1, 30, ok);
        go_btn = 1'b1; led_in = 4'd1;
        step(4);
        check("abort_state", 32'(dut.state), 32'(WAIT_DONE));
        base = pulses;
        rst_btn = 1'b0;
        #1;
        check("abort_go", 32'(go), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_count", 32'(run_count), 0);
        check("abort_err", 32'(err), 0);
        check("abort_done_pulse", 32'(done_pulse), 0);
        step(2);
        rst_btn = 1'b1;
        step(2);
        done_sig = 1'b1;
        step(10);
        check("abort_no_pulse", pulses - base, 0);
        check("abort_busy_after", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
